// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) types, syndrome constants and the syndrome function.
// The encoder reuses calc_syndrome with zeroed parity bits to generate its parity.
package hamming74_pkg;

    localparam logic [2:0] SYN_C0 = 3'b011;
    localparam logic [2:0] SYN_C1 = 3'b101;
    localparam logic [2:0] SYN_C2 = 3'b110;
    localparam logic [2:0] SYN_C3 = 3'b111;
    localparam logic [2:0] SYN_C4 = 3'b001;
    localparam logic [2:0] SYN_C5 = 3'b010;
    localparam logic [2:0] SYN_C6 = 3'b100;

    typedef logic [0:6] code_t;
    typedef logic [0:3] data_t;

    typedef enum logic {
        ST_IDLE,
        ST_OPEN
    } frame_state_t;

    // Returns {s2,s1,s0}
    function automatic logic [2:0] calc_syndrome(code_t c);
        logic s0;
        logic s1;
        logic s2;
        s0 = c[4] ^ c[0] ^ c[1] ^ c[3];
        s1 = c[5] ^ c[0] ^ c[2] ^ c[3];
        s2 = c[6] ^ c[1] ^ c[2] ^ c[3];
        return {s2, s1, s0};
    endfunction

endpackage

// File: rtl/hamming74_decoder_if.sv
// Codeword input stream and decoded output stream of the Hamming(7,4) decoder.
interface hamming74_decoder_if;
    import hamming74_pkg::*;

    logic       in_valid;
    code_t      code_in;
    logic       out_valid;
    data_t      data_out;
    logic       corrected;
    logic [2:0] syndrome;
    logic       frame_done;

    modport master (
        output in_valid, code_in,
        input  out_valid, data_out, corrected, syndrome, frame_done
    );

    modport slave (
        input  in_valid, code_in,
        output out_valid, data_out, corrected, syndrome, frame_done
    );

endinterface

// File: rtl/hamming74_syndrome.sv
// Combinational syndrome and correction mask for one codeword.
// Parity-bit errors need no data flip, so the mask only spans the data bits.
module hamming74_syndrome
    import hamming74_pkg::*;
(
    input  code_t      code,
    output logic [2:0] syndrome,
    output data_t      data_mask
);

    always_comb begin
        syndrome  = calc_syndrome(code);
        data_mask = '0;
        case (syndrome)
            SYN_C0:  data_mask[0] = 1'b1;
            SYN_C1:  data_mask[1] = 1'b1;
            SYN_C2:  data_mask[2] = 1'b1;
            SYN_C3:  data_mask[3] = 1'b1;
            SYN_C4, SYN_C5, SYN_C6: data_mask = '0;
            default: data_mask = '0;
        endcase
    end

endmodule

// File: rtl/hamming74_decoder.sv
// Framed, 2-stage pipelined Hamming(7,4) decoder with single-error correction
// and a saturating count of corrected words.
module hamming74_decoder
    import hamming74_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active,
    input  logic               clear_cnt,
    hamming74_decoder_if.slave stream,
    output logic               busy,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    frame_state_t state;
    frame_state_t state_nxt;
    logic [7:0]   word_cnt;
    logic         accept;
    logic         last_word;

    logic [2:0]   syn_c;
    data_t        mask_c;

    logic         s1_valid;
    logic         s1_last;
    data_t        s1_data;
    data_t        s1_mask;
    logic [2:0]   s1_syn;

    logic         out_valid_q;
    data_t        data_out_q;
    logic         corrected_q;
    logic [2:0]   syndrome_q;
    logic         frame_done_q;

    hamming74_syndrome u_syndrome (
        .code      (stream.code_in),
        .syndrome  (syn_c),
        .data_mask (mask_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A word is only accepted inside an open frame; the opening cycle never accepts.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_word = 1'b0;
        case (state)
            ST_IDLE: begin
                if (active) begin
                    state_nxt = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (stream.in_valid) begin
                    accept = 1'b1;
                    if (word_cnt == LAST_IDX) begin
                        last_word = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt <= '0;
        end else if (state == ST_IDLE && active) begin
            word_cnt <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s1_mask  <= '0;
            s1_syn   <= '0;
        end else begin
            s1_valid <= accept;
            s1_last  <= last_word;
            if (accept) begin
                s1_data <= stream.code_in[0:3];
                s1_mask <= mask_c;
                s1_syn  <= syn_c;
            end
        end
    end

    // Output fields only change when a word arrives, so they hold between words.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            data_out_q   <= '0;
            corrected_q  <= 1'b0;
            syndrome_q   <= '0;
        end else begin
            out_valid_q  <= s1_valid;
            frame_done_q <= s1_valid & s1_last;
            if (s1_valid) begin
                data_out_q  <= s1_data ^ s1_mask;
                corrected_q <= (s1_syn != 3'b000);
                syndrome_q  <= s1_syn;
            end
        end
    end

    // Counts a corrected word on the edge after it is presented; clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (clear_cnt) begin
            err_cnt <= '0;
        end else if (out_valid_q && corrected_q && err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign busy              = (state == ST_OPEN) | s1_valid | out_valid_q;
    assign stream.out_valid  = out_valid_q;
    assign stream.data_out   = data_out_q;
    assign stream.corrected  = corrected_q;
    assign stream.syndrome   = syndrome_q;
    assign stream.frame_done = frame_done_q;

endmodule

// File: tb/tb_hamming74_decoder.sv
// Self-checking bench for hamming74_decoder: a nearest-codeword reference model
// with a frame-acceptance model predicts every output word and its arrival cycle.
module tb_hamming74_decoder;

    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = 2;
    localparam int ERR_MAX   = (1 << CNT_W) - 1;
    localparam logic [2:0] POS_SYN [7] = '{3'b011, 3'b101, 3'b110, 3'b111, 3'b001, 3'b010, 3'b100};

    typedef struct packed {
        logic [0:3] data;
        logic       corr;
        logic [2:0] syn;
        logic       last;
        int         stamp;
    } word_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             active;
    logic             clear_cnt;
    logic             busy;
    logic [CNT_W-1:0] err_cnt;

    hamming74_decoder_if bus ();

    hamming74_decoder #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .clear_cnt (clear_cnt),
        .stream    (bus.slave),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    ncyc   = 0;
    word_t obs_q [$];
    word_t exp_q [$];
    bit    m_open = 1'b0;
    int    m_cnt  = 0;
    int    m_err  = 0;

    // Records every presented output word together with the cycle it appeared in.
    always @(negedge clk) begin
        ncyc++;
        if (bus.out_valid === 1'b1) begin
            obs_q.push_back('{data: bus.data_out, corr: bus.corrected, syn: bus.syndrome,
                              last: bus.frame_done, stamp: ncyc});
        end
    end

    function automatic logic [0:6] encode(logic [0:3] d);
        logic [0:6] c;
        c[0:3] = d;
        c[4]   = d[0] ^ d[1] ^ d[3];
        c[5]   = d[0] ^ d[2] ^ d[3];
        c[6]   = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    // Decodes by searching all 16 codewords for the one within distance 1.
    function automatic word_t ref_decode(logic [0:6] c, logic last, int stamp);
        word_t      w;
        logic [0:6] e;
        w = '0;
        e = '0;
        for (int d = 0; d < 16; d++) begin
            if ($countones(c ^ encode(4'(d))) <= 1) begin
                w.data = 4'(d);
                e      = c ^ encode(4'(d));
            end
        end
        w.corr = (e != 7'b0);
        w.syn  = 3'b000;
        for (int i = 0; i < 7; i++) begin
            if (e[i]) w.syn = POS_SYN[i];
        end
        w.last  = last;
        w.stamp = stamp;
        return w;
    endfunction

    function automatic logic [0:6] rand_code(bit corrupt);
        logic [0:6] c;
        int         p;
        c = encode(4'($urandom_range(0, 15)));
        if (corrupt) begin
            p    = $urandom_range(0, 6);
            c[p] = ~c[p];
        end
        return c;
    endfunction

    // Drives one cycle of inputs and advances the frame/pipeline model accordingly.
    task automatic drive_cycle(input logic rst, input logic act, input logic iv,
                               input logic [0:6] code, input logic clr);
        int    m;
        word_t w;
        @(posedge clk);
        #1;
        reset        = rst;
        active       = act;
        bus.in_valid = iv;
        bus.code_in  = code;
        clear_cnt    = clr;
        m = ncyc;
        if (rst) begin
            m_open = 1'b0;
            m_cnt  = 0;
            m_err  = 0;
            while (exp_q.size() > 0 && exp_q[$].stamp >= m + 2) void'(exp_q.pop_back());
        end else if (!m_open) begin
            if (act) begin
                m_open = 1'b1;
                m_cnt  = 0;
            end
        end else if (iv) begin
            w = ref_decode(code, (m_cnt + 1 == FRAME_LEN), m + 3);
            exp_q.push_back(w);
            if (w.corr && m_err < ERR_MAX) m_err++;
            m_cnt++;
            if (m_cnt == FRAME_LEN) m_open = 1'b0;
        end
        if (clr) m_err = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, rand_code(1'b0), 1'b0);
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 7'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 7'b0, 1'b0);
        checks++;
        if ({bus.out_valid, bus.corrected, bus.frame_done, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got valid/corr/done/busy=%b, expected 0000",
                     {bus.out_valid, bus.corrected, bus.frame_done, busy});
        end
        checks++;
        if ({bus.data_out, bus.syndrome} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_fields: got data=%b syn=%b, expected 0000/000", bus.data_out, bus.syndrome);
        end
        checks++;
        if (err_cnt !== 2'(m_err)) begin
            errors++;
            $display("[TB] FAIL reset_err_cnt: got %0d, expected %0d", err_cnt, m_err);
        end
        idle(2);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_clean_frame();
        logic [0:6] codes [4] = '{7'b1011010, 7'b0000000, 7'b1111111, 7'b1000110};
        logic [0:3] datas [4] = '{4'b1011, 4'b0000, 4'b1111, 4'b1000};
        drive_cycle(1'b0, 1'b1, 1'b0, 7'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, codes[i], 1'b0);
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL clean_busy_open: got %b, expected 1", busy);
                end
            end
        end
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL clean_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].data !== datas[i] || obs_q[i].last !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL clean_word%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (err_cnt !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clean_end: got err_cnt=%0d busy=%b, expected 0/0", err_cnt, busy);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single_error(input string name, input logic [0:6] code,
                                     input logic [2:0] syn_req);
        int prev;
        prev = m_err;
        drive_cycle(1'b0, 1'b1, 1'b0, 7'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, code, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b0), 1'b0);
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d words, expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL %s_word%0d: got %h, expected %h", name, i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].syn !== syn_req || obs_q[0].data !== 4'b1011 || obs_q[0].corr !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s_fields: got syn=%b data=%b corr=%b, expected %b/1011/1",
                         name, obs_q[0].syn, obs_q[0].data, obs_q[0].corr, syn_req);
            end
        end
        checks++;
        if (err_cnt !== 2'(prev + 1)) begin
            errors++;
            $display("[TB] FAIL %s_err_cnt: got %0d, expected %0d", name, err_cnt, prev + 1);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_framing();
        drive_cycle(1'b0, 1'b0, 1'b0, 7'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b0), 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b1), 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 7'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b0), 1'b0);
        idle(1);
        drive_cycle(1'b0, 1'b1, 1'b1, rand_code(1'b0), 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, (i == 1), 1'b1, rand_code(i == 2), 1'b0);
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 8) begin
            errors++;
            $display("[TB] FAIL framing_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL framing_word%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_saturation();
        drive_cycle(1'b0, 1'b0, 1'b0, 7'b0, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b0, 7'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b1), 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 7'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b1), 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b0), 1'b0);
        idle(4);
        checks++;
        if (err_cnt !== 2'd3 || m_err != 3) begin
            errors++;
            $display("[TB] FAIL sat_err_cnt: got %0d, expected 3", err_cnt);
        end
        // Clear while idle, then clear again exactly when a corrected word is presented.
        drive_cycle(1'b0, 1'b0, 1'b0, 7'b0, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b0, 7'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b1), 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 7'b0, 1'b1);
        idle(3);
        checks++;
        if (err_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL clear_priority: got %0d, expected 0", err_cnt);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b0), 1'b0);
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL sat_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL sat_word%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        drive_cycle(1'b0, 1'b1, 1'b0, 7'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b1), 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b0), 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 7'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, rand_code(1'b0), 1'b0);
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || err_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got busy=%b valid=%b err_cnt=%0d, expected 0/0/0",
                     busy, bus.out_valid, err_cnt);
        end
        idle(3);
        checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL midreset_flush: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end
        obs_q.delete();
        exp_q.delete();
        drive_cycle(1'b0, 1'b1, 1'b0, 7'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, rand_code(i[0]), 1'b0);
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL midreset_refill_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL midreset_word%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Random frames with gaps; each new active arrives while the previous frame drains.
    task automatic test_back_to_back();
        int guard;
        for (int f = 0; f < 6; f++) begin
            drive_cycle(1'b0, 1'b1, $urandom_range(0, 1), rand_code(1'b0), 1'b0);
            guard = 0;
            while (m_open && guard < 40) begin
                drive_cycle(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
                            rand_code($urandom_range(0, 1)), 1'b0);
                guard++;
            end
        end
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL b2b_word%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (err_cnt !== 2'(m_err) || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got err_cnt=%0d busy=%b, expected %0d/0", err_cnt, busy, m_err);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset        = 1'b1;
        active       = 1'b0;
        clear_cnt    = 1'b0;
        bus.in_valid = 1'b0;
        bus.code_in  = '0;
        test_reset();
        test_clean_frame();
        test_single_error("data_err", 7'b1111010, 3'b101);
        test_single_error("parity_err", 7'b1011000, 3'b010);
        test_framing();
        test_saturation();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming74_decoder.md
# hamming74_decoder

Streaming Hamming(7,4) decoder: the receive-side counterpart of the team's 7-bit Hamming encoder. It accepts framed 7-bit codewords, computes the 3-bit syndrome, corrects any single-bit error, and emits the 4 data bits through a 2-stage pipeline. It also keeps a saturating count of corrected words. It sits after the channel/deserializer and feeds the 4-bit data consumer.

## Interface
Parameters:
- FRAME_LEN, 4: codewords accepted per frame after `active`; legal range 1..255.
- CNT_W, 8: width of the corrected-error counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- active  in  1  frame-start pulse; ignored while a frame is open.
- in_valid  in  1  code_in is valid this cycle.
- code_in  in  [0:6]  codeword. c[0..3] = d0..d3; c4 = d0^d1^d3; c5 = d0^d2^d3; c6 = d1^d2^d3.
- data_out  out  [0:3]  corrected d0..d3.
- out_valid  out  1  data_out, corrected and syndrome are valid.
- corrected  out  1  a single-bit error was corrected in this word.
- syndrome  out  [2:0]  {s2,s1,s0} for this word.
- frame_done  out  1  one-cycle pulse, coincident with out_valid of the frame's last word.
- busy  out  1  a frame is open, or words are still in the pipeline.
- err_cnt  out  [CNT_W-1:0]  saturating count of corrected words.
- clear_cnt  in  1  synchronously zeroes err_cnt.

## Operation
- Frame control has two states:
  - IDLE: `active`=1 moves to OPEN and loads the word counter with 0.
  - OPEN: each in_valid=1 cycle accepts code_in and increments the counter. Acceptance of word number FRAME_LEN returns the block to IDLE.
- Acceptance rules:
  - in_valid in IDLE is dropped silently.
  - `active` in the same cycle as in_valid while IDLE opens the frame, but does not accept that word.
  - `active` while OPEN has no effect.
- Syndrome:
  - s0 = c4^c0^c1^c3; s1 = c5^c0^c2^c3; s2 = c6^c1^c2^c3.
- Correction map ({s2,s1,s0} → bit flipped):
  - 011 → c0; 101 → c1; 110 → c2; 111 → c3.
  - 001 → c4; 010 → c5; 100 → c6.
  - 000 → no flip.
- corrected = (syndrome != 0). Parity-bit errors also assert corrected; data_out is then unchanged from c[0:3].
- Double errors are miscorrected by design. No detection is required.
- err_cnt:
  - +1 on each out_valid with corrected=1.
  - Saturates at 2^CNT_W-1.
  - clear_cnt has priority over a simultaneous increment; the result is 0.

## Timing
- Latency is 2 cycles:
  - Stage 1 registers the codeword and syndrome on acceptance (edge N).
  - Stage 2 registers the corrected outputs; out_valid is high after edge N+1.
- Throughput is 1 word/cycle. There is no backpressure.
- Every out_valid is preceded by an accepted word exactly 2 edges earlier.
- Between output words, out_valid=0 and data_out/corrected/syndrome hold their last values.
- busy = OPEN, or either pipeline stage is valid. busy falls the cycle after frame_done.
- A new `active` may be issued while the last words drain (state is IDLE). The new frame's outputs follow the old ones in order.
- Reset values: data_out=0, out_valid=0, corrected=0, syndrome=0, frame_done=0, busy=0, err_cnt=0.
- Reset mid-frame flushes both pipeline stages. No out_valid follows for words already in flight, and the state returns to IDLE.

## Structure
- Package `hamming74_pkg` holds:
  - constants SYN_C0..SYN_C6 (3'b011, 3'b101, 3'b110, 3'b111, 3'b001, 3'b010, 3'b100);
  - typedef `code_t` (logic [0:6]) and typedef `data_t` (logic [0:3]);
  - function `calc_syndrome(code_t)`. The encoder reuses it for parity.
- One sub-module, `hamming74_syndrome`: combinational syndrome and correction mask. The top level holds the FSM, counters and pipeline registers.

## Test plan
- Clean frame: active, then codewords 7'b1011010, 7'b0000000, 7'b1111111, 7'b1000110 on consecutive cycles.
  - Required: data 1011, 0000, 1111, 1000 with corrected=0.
  - frame_done on the 4th word; err_cnt=0.
- Data error: 7'b1111010 (c1 flipped).
  - Required: syndrome=101, data_out=1011, corrected=1, err_cnt increments by 1.
- Parity error: 7'b1011000 (c5 flipped).
  - Required: syndrome=010, data_out=1011, corrected=1.
- Framing edges:
  - in_valid while IDLE gives no output.
  - A 5th word after a FRAME_LEN=4 frame is dropped.
  - active plus in_valid in the same IDLE cycle: that word is dropped.
- Saturation with CNT_W=2: 5 corrupted words give err_cnt=3.
  - clear_cnt coincident with a corrected output gives err_cnt=0.
- Reset mid-frame: reset asserted 1 cycle after the 2nd accepted word.
  - Required: no further out_valid, busy=0, and a new active/frame works normally.
